// File: rtl/count_mon_pkg.sv
// Shared types and default sizing for the count wrap monitor.
// Included first so the sync stage and the top agree on defaults.
package count_mon_pkg;

  localparam int W_DEF           = 4;
  localparam int STALL_LIMIT_DEF = 8;
  localparam int WRAP_W_DEF      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    STALL = 2'd2,
    ERR   = 2'd3
  } mon_state_e;

endpackage

// File: rtl/count_wrap_monitor_sync.sv
// Two-flop synchronizer for the free-running upstream count.
// Synchronous active-low clear.
module count_sync
  import count_mon_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/count_wrap_monitor.sv
// Watches a synchronized counter for wraps, stalls and illegal steps.
// All outputs come straight from flops.
module count_wrap_monitor
  import count_mon_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF,
  parameter int WRAP_W      = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [W-1:0]      count_in,
  input  logic              ack,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              stalled,
  output logic              step_err,
  output logic [1:0]        state
);

  localparam int SCW = $clog2(STALL_LIMIT + 1);

  localparam logic [W-1:0]      CNT_MAX   = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX  = '1;
  localparam logic [SCW-1:0]    STALL_LIM = SCW'(STALL_LIMIT);

  mon_state_e        state_q, state_d;
  logic [W-1:0]      cur;
  logic [W-1:0]      prev_q, prev_d;
  logic [SCW-1:0]    stall_q, stall_d;
  logic [WRAP_W-1:0] wcnt_q, wcnt_d;
  logic              wrap_q, wrap_d;
  logic              stalled_q, stalled_d;
  logic              err_q, err_d;
  logic              same, step, wrap;

  count_sync #(.W(W)) u_sync (
    .clk (clk),
    .clr (clr),
    .d_i (count_in),
    .q_o (cur)
  );

  assign same = (cur == prev_q);
  assign step = (cur == prev_q + W'(1));
  assign wrap = (prev_q == CNT_MAX) && (cur == '0);

  always_comb begin
    state_d   = state_q;
    prev_d    = cur;
    stall_d   = stall_q;
    wcnt_d    = wcnt_q;
    wrap_d    = 1'b0;
    stalled_d = stalled_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        state_d = TRACK;
        stall_d = '0;
      end
      TRACK: begin
        if (step) begin
          stall_d = '0;
        end else if (same) begin
          stall_d = stall_q + 1'b1;
          if (stall_d == STALL_LIM) begin
            state_d   = STALL;
            stalled_d = 1'b1;
          end
        end else begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      STALL: begin
        if (step) begin
          state_d   = TRACK;
          stalled_d = 1'b0;
          stall_d   = '0;
        end else if (!same) begin
          state_d   = ERR;
          stalled_d = 1'b0;
          err_d     = 1'b1;
          stall_d   = '0;
        end
      end
      ERR: begin
        // prev stays put so the error context survives until ack
        prev_d  = prev_q;
        stall_d = '0;
        if (ack) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
    endcase
    if (wrap && (state_q == TRACK || state_q == STALL)) begin
      wrap_d = 1'b1;
      if (wcnt_q != WRAP_MAX) begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      stall_q   <= '0;
      wcnt_q    <= '0;
      wrap_q    <= 1'b0;
      stalled_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      stall_q   <= stall_d;
      wcnt_q    <= wcnt_d;
      wrap_q    <= wrap_d;
      stalled_q <= stalled_d;
      err_q     <= err_d;
    end
  end

  assign wrap_pulse = wrap_q;
  assign wrap_cnt   = wcnt_q;
  assign stalled    = stalled_q;
  assign step_err   = err_q;
  assign state      = state_q;

endmodule
